// File: rtl/lbist_pkg.sv
// LBIST sequencer shared definitions: register map, CTRL bits, FSM states.
package lbist_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic [ADDR_W-1:0] ADDR_CTRL = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_CFG  = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_SIG  = 2'd2;

  localparam int unsigned CTRL_SRST  = 0;
  localparam int unsigned CTRL_START = 1;
  localparam int unsigned CTRL_DONE  = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_CFG,
    ST_WR_SRST,
    ST_WR_START,
    ST_POLL_WAIT,
    ST_RD_CTRL,
    ST_RD_SIG,
    ST_WR_CLR,
    ST_NEXT,
    ST_DONE
  } state_t;

  // One register-bus request as presented to the bus master.
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } reg_req_t;

  // Build a CTRL write value from its control bits.
  function automatic logic [DATA_W-1:0] ctrl_word(input logic srst, input logic start);
    logic [DATA_W-1:0] w;
    w             = '0;
    w[CTRL_SRST]  = srst;
    w[CTRL_START] = start;
    return w;
  endfunction

endpackage

// File: rtl/lbist_reg_master.sv
// Single-outstanding register-bus master: turns a req/cmd pulse into a held cs/ack cycle.
module lbist_reg_master
  import lbist_pkg::*;
(
  input  logic              mclk,
  input  logic              reset_n,
  input  logic              req,
  input  reg_req_t          cmd,
  output logic              done_c,
  output logic [DATA_W-1:0] rdata_c,
  output logic              reg_cs,
  output logic              reg_wr,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic [BE_W-1:0]   reg_be,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic              reg_ack
);

  // Request fields are latched at issue and held until the ack cycle.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      reg_cs    <= 1'b0;
      reg_wr    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_be    <= '0;
    end else if (reg_cs) begin
      if (reg_ack) reg_cs <= 1'b0;
    end else if (req) begin
      reg_cs    <= 1'b1;
      reg_wr    <= cmd.wr;
      reg_addr  <= cmd.addr;
      reg_wdata <= cmd.wdata;
      reg_be    <= 4'hF;
    end
  end

  // Completion is visible to the sequencer in the ack cycle itself.
  assign done_c  = reg_cs & reg_ack;
  assign rdata_c = reg_rdata;

endmodule

// File: rtl/lbist_seq.sv
// LBIST sequencer: runs each configured test entry over the register bus and reports pass/fail.
module lbist_seq
  import lbist_pkg::*;
#(
  parameter int unsigned NCFG     = 4,
  parameter int unsigned POLL_GAP = 16,
  parameter int unsigned POLL_MAX = 1024
) (
  input  logic                mclk,
  input  logic                reset_n,
  input  logic                seq_start,
  input  logic                seq_abort,
  input  logic [1:0]          cfg_num,
  input  logic [NCFG*16-1:0]  cfg_pat,
  input  logic [NCFG*16-1:0]  cfg_depth,
  input  logic [NCFG*32-1:0]  cfg_golden,
  output logic                reg_cs,
  output logic                reg_wr,
  output logic [ADDR_W-1:0]   reg_addr,
  output logic [DATA_W-1:0]   reg_wdata,
  output logic [BE_W-1:0]     reg_be,
  input  logic [DATA_W-1:0]   reg_rdata,
  input  logic                reg_ack,
  output logic                seq_busy,
  output logic                seq_done,
  output logic                seq_pass,
  output logic                seq_aborted,
  output logic [NCFG-1:0]     seq_fail_mask,
  output logic [DATA_W-1:0]   seq_last_sig
);

  localparam int unsigned GAP_W  = $clog2(POLL_GAP + 1);
  localparam int unsigned POLL_W = $clog2(POLL_MAX + 1);

  state_t              state;
  state_t              state_next;
  logic                req;
  reg_req_t            cmd;
  logic                done_c;
  logic [DATA_W-1:0]   rdata_c;
  logic [1:0]          cfg_num_q;
  logic [1:0]          idx;
  logic                abort_pend;
  logic                abort_now;
  logic                bail;
  logic [GAP_W-1:0]    gap_cnt;
  logic [POLL_W-1:0]   poll_cnt;
  logic                gap_last;
  logic                poll_last;
  logic [15:0]         pat_cur;
  logic [15:0]         depth_cur;
  logic [DATA_W-1:0]   golden_cur;

  assign pat_cur    = cfg_pat[32'(idx)*16 +: 16];
  assign depth_cur  = cfg_depth[32'(idx)*16 +: 16];
  assign golden_cur = cfg_golden[32'(idx)*32 +: 32];

  // An abort is honoured from any busy state except DONE, where the run is already ending.
  assign abort_now = abort_pend | (seq_abort & (state != ST_IDLE) & (state != ST_DONE));
  // Leave for WR_CLR once nothing is outstanding on the bus.
  assign bail      = abort_now & (~reg_cs | done_c);
  assign gap_last  = (gap_cnt == GAP_W'(POLL_GAP - 1));
  assign poll_last = (poll_cnt == POLL_W'(POLL_MAX - 1));

  lbist_reg_master u_master (
    .mclk      (mclk),
    .reset_n   (reset_n),
    .req       (req),
    .cmd       (cmd),
    .done_c    (done_c),
    .rdata_c   (rdata_c),
    .reg_cs    (reg_cs),
    .reg_wr    (reg_wr),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_be    (reg_be),
    .reg_rdata (reg_rdata),
    .reg_ack   (reg_ack)
  );

  // State register.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next state and bus request for the current step.
  always_comb begin
    state_next = state;
    req        = 1'b0;
    cmd        = '0;
    unique case (state)
      ST_IDLE: begin
        if (seq_start) state_next = ST_WR_CFG;
      end
      ST_WR_CFG: begin
        cmd.wr    = 1'b1;
        cmd.addr  = ADDR_CFG;
        cmd.wdata = {depth_cur, pat_cur};
        req       = ~reg_cs & ~abort_now;
        if (bail)        state_next = ST_WR_CLR;
        else if (done_c) state_next = ST_WR_SRST;
      end
      ST_WR_SRST: begin
        cmd.wr    = 1'b1;
        cmd.addr  = ADDR_CTRL;
        cmd.wdata = ctrl_word(1'b1, 1'b0);
        req       = ~reg_cs & ~abort_now;
        if (bail)        state_next = ST_WR_CLR;
        else if (done_c) state_next = ST_WR_START;
      end
      ST_WR_START: begin
        cmd.wr    = 1'b1;
        cmd.addr  = ADDR_CTRL;
        cmd.wdata = ctrl_word(1'b0, 1'b1);
        req       = ~reg_cs & ~abort_now;
        if (bail)        state_next = ST_WR_CLR;
        else if (done_c) state_next = ST_POLL_WAIT;
      end
      ST_POLL_WAIT: begin
        if (abort_now)     state_next = ST_WR_CLR;
        else if (gap_last) state_next = ST_RD_CTRL;
      end
      ST_RD_CTRL: begin
        cmd.addr = ADDR_CTRL;
        req      = ~reg_cs & ~abort_now;
        if (bail) state_next = ST_WR_CLR;
        else if (done_c) begin
          if (rdata_c[CTRL_DONE]) state_next = ST_RD_SIG;
          else if (poll_last)     state_next = ST_WR_CLR;
          else                    state_next = ST_POLL_WAIT;
        end
      end
      ST_RD_SIG: begin
        cmd.addr = ADDR_SIG;
        req      = ~reg_cs & ~abort_now;
        if (bail)        state_next = ST_WR_CLR;
        else if (done_c) state_next = ST_WR_CLR;
      end
      ST_WR_CLR: begin
        cmd.wr    = 1'b1;
        cmd.addr  = ADDR_CTRL;
        cmd.wdata = ctrl_word(1'b0, 1'b0);
        req       = ~reg_cs;
        if (done_c) state_next = abort_now ? ST_DONE : ST_NEXT;
      end
      ST_NEXT: begin
        if (abort_now)              state_next = ST_WR_CLR;
        else if (idx == cfg_num_q)  state_next = ST_DONE;
        else                        state_next = ST_WR_CFG;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Sequencing counters, per-entry results and status outputs.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_num_q     <= '0;
      idx           <= '0;
      abort_pend    <= 1'b0;
      gap_cnt       <= '0;
      poll_cnt      <= '0;
      seq_busy      <= 1'b0;
      seq_done      <= 1'b0;
      seq_pass      <= 1'b0;
      seq_aborted   <= 1'b0;
      seq_fail_mask <= '0;
      seq_last_sig  <= '0;
    end else begin
      seq_busy <= (state_next != ST_IDLE);
      seq_done <= 1'b0;

      if (state == ST_IDLE && seq_start) begin
        cfg_num_q     <= cfg_num;
        idx           <= '0;
        abort_pend    <= 1'b0;
        seq_fail_mask <= '0;
        seq_aborted   <= 1'b0;
        seq_pass      <= 1'b0;
      end else if (state == ST_DONE) begin
        abort_pend <= 1'b0;
      end else if (abort_now) begin
        abort_pend <= 1'b1;
      end

      if (state == ST_POLL_WAIT) gap_cnt <= gap_cnt + GAP_W'(1);
      else                       gap_cnt <= '0;

      if (state == ST_WR_CFG) begin
        poll_cnt <= '0;
      end else if (state == ST_RD_CTRL && done_c && !rdata_c[CTRL_DONE]) begin
        if (poll_last) seq_fail_mask[idx] <= 1'b1;
        else           poll_cnt <= poll_cnt + POLL_W'(1);
      end

      if (state == ST_RD_SIG && done_c) begin
        seq_last_sig <= rdata_c;
        if (rdata_c != golden_cur) seq_fail_mask[idx] <= 1'b1;
      end

      if (state == ST_NEXT && state_next == ST_WR_CFG) idx <= idx + 2'd1;

      if (state_next == ST_DONE && state != ST_DONE) begin
        seq_done <= 1'b1;
        seq_pass <= (seq_fail_mask == '0) & ~abort_now;
        if (abort_now) seq_aborted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lbist_seq.sv
// Scoreboard bench for lbist_seq: expected bus transactions and end status are queued by the
// stimulus and consumed by independent monitors; a bus responder models the LBIST registers.
`timescale 1ns/1ps
module tb_lbist_seq;

  localparam int unsigned NCFG     = 4;
  localparam int unsigned POLL_GAP = 2;
  localparam int unsigned POLL_MAX = 4;

  typedef struct packed {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct packed {
    logic        pass;
    logic        aborted;
    logic [3:0]  mask;
    logic [31:0] sig;
  } stat_exp_t;

  logic              mclk;
  logic              reset_n;
  logic              seq_start;
  logic              seq_abort;
  logic [1:0]        cfg_num;
  logic [NCFG*16-1:0] cfg_pat;
  logic [NCFG*16-1:0] cfg_depth;
  logic [NCFG*32-1:0] cfg_golden;
  logic              reg_cs;
  logic              reg_wr;
  logic [1:0]        reg_addr;
  logic [31:0]       reg_wdata;
  logic [3:0]        reg_be;
  logic [31:0]       reg_rdata;
  logic              reg_ack;
  logic              seq_busy;
  logic              seq_done;
  logic              seq_pass;
  logic              seq_aborted;
  logic [NCFG-1:0]   seq_fail_mask;
  logic [31:0]       seq_last_sig;

  bus_exp_t  bus_q[$];
  stat_exp_t stat_q[$];
  int checks = 0;
  int errors = 0;

  int          ack_delay  = 0;
  int          done_after = 0;
  int          rsp_entry  = 0;
  int          rsp_poll   = 0;
  logic [31:0] sig_tab [4];

  lbist_seq #(.NCFG(NCFG), .POLL_GAP(POLL_GAP), .POLL_MAX(POLL_MAX)) dut (
    .mclk          (mclk),
    .reset_n       (reset_n),
    .seq_start     (seq_start),
    .seq_abort     (seq_abort),
    .cfg_num       (cfg_num),
    .cfg_pat       (cfg_pat),
    .cfg_depth     (cfg_depth),
    .cfg_golden    (cfg_golden),
    .reg_cs        (reg_cs),
    .reg_wr        (reg_wr),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .reg_be        (reg_be),
    .reg_rdata     (reg_rdata),
    .reg_ack       (reg_ack),
    .seq_busy      (seq_busy),
    .seq_done      (seq_done),
    .seq_pass      (seq_pass),
    .seq_aborted   (seq_aborted),
    .seq_fail_mask (seq_fail_mask),
    .seq_last_sig  (seq_last_sig)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // LBIST register model: acks after ack_delay cycles; CTRL reports done from poll done_after on.
  initial begin
    int wait_cnt;
    reg_ack   = 1'b0;
    reg_rdata = 32'h0;
    wait_cnt  = 0;
    forever begin
      @(negedge mclk);
      if (reg_ack) begin
        reg_ack = 1'b0;
      end else if (!reg_cs) begin
        wait_cnt = 0;
      end else if (wait_cnt < ack_delay) begin
        wait_cnt++;
      end else begin
        wait_cnt  = 0;
        reg_rdata = 32'h0;
        if (reg_wr && reg_addr == 2'd1) begin
          rsp_entry++;
          rsp_poll = 0;
        end else if (!reg_wr && reg_addr == 2'd0) begin
          rsp_poll++;
          reg_rdata = (done_after != 0 && rsp_poll >= done_after) ? 32'h0000_0004 : 32'hFFFF_FFFB;
        end else if (!reg_wr && reg_addr == 2'd2) begin
          reg_rdata = sig_tab[(rsp_entry - 1) & 3];
        end
        reg_ack = 1'b1;
      end
    end
  end

  // Bus monitor: every acked transaction is compared with the head of the expected queue.
  always @(negedge mclk) begin
    bus_exp_t e;
    #1;
    if (reset_n && reg_cs && reg_ack) begin
      checks++;
      if (bus_q.size() == 0) begin
        errors++;
        $display("FAIL bus_unexpected: got wr=%0b addr=%0d wdata=%h, required no transaction",
                 reg_wr, reg_addr, reg_wdata);
      end else begin
        e = bus_q.pop_front();
        if (reg_wr !== e.wr || reg_addr !== e.addr || reg_be !== 4'hF ||
            (e.wr && reg_wdata !== e.wdata)) begin
          errors++;
          $display("FAIL bus_txn: got wr=%0b addr=%0d wdata=%h be=%h, required wr=%0b addr=%0d wdata=%h be=f",
                   reg_wr, reg_addr, reg_wdata, reg_be, e.wr, e.addr, e.wdata);
        end
      end
    end
  end

  // Status monitor: compared on every seq_done pulse.
  always @(negedge mclk) begin
    stat_exp_t s;
    if (reset_n && seq_done) begin
      checks++;
      if (stat_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: got seq_done=1, required no completion");
      end else begin
        s = stat_q.pop_front();
        if ({seq_pass, seq_aborted, seq_fail_mask, seq_last_sig} !== s) begin
          errors++;
          $display("FAIL done_status: got pass=%0b aborted=%0b mask=%b sig=%h, required pass=%0b aborted=%0b mask=%b sig=%h",
                   seq_pass, seq_aborted, seq_fail_mask, seq_last_sig, s.pass, s.aborted, s.mask, s.sig);
        end
      end
    end
  end

  // Request stability: while cs is high and not yet acked, cs/addr/wdata must hold.
  logic        hold_prev = 1'b0;
  logic [1:0]  addr_prev;
  logic [31:0] wdata_prev;
  always @(negedge mclk) begin
    #3;
    if (reset_n && hold_prev) begin
      checks++;
      if (!reg_cs || reg_addr !== addr_prev || reg_wdata !== wdata_prev) begin
        errors++;
        $display("FAIL req_hold: got cs=%0b addr=%0d wdata=%h, required cs=1 addr=%0d wdata=%h",
                 reg_cs, reg_addr, reg_wdata, addr_prev, wdata_prev);
      end
    end
    hold_prev  = reset_n && reg_cs && !reg_ack;
    addr_prev  = reg_addr;
    wdata_prev = reg_wdata;
  end

  task automatic set_entry(input int i, input logic [15:0] pat, input logic [15:0] depth,
                           input logic [31:0] golden, input logic [31:0] rsp);
    cfg_pat[i*16 +: 16]    = pat;
    cfg_depth[i*16 +: 16]  = depth;
    cfg_golden[i*32 +: 32] = golden;
    sig_tab[i]             = rsp;
  endtask

  task automatic exp_bus(input logic wr, input logic [1:0] addr, input logic [31:0] wdata);
    bus_q.push_back({wr, addr, wdata});
  endtask

  // One full entry: CFG, SRST, START, polls, optional SIG read, CLR.
  task automatic exp_entry(input logic [31:0] cfg_word, input int polls, input bit sig_read);
    exp_bus(1'b1, 2'd1, cfg_word);
    exp_bus(1'b1, 2'd0, 32'd1);
    exp_bus(1'b1, 2'd0, 32'd2);
    for (int k = 0; k < polls; k++) exp_bus(1'b0, 2'd0, 32'd0);
    if (sig_read) exp_bus(1'b0, 2'd2, 32'd0);
    exp_bus(1'b1, 2'd0, 32'd0);
  endtask

  task automatic start_seq(input logic [1:0] num, input logic with_abort);
    rsp_entry = 0;
    rsp_poll  = 0;
    cfg_num   = num;
    @(negedge mclk);
    seq_start = 1'b1;
    seq_abort = with_abort;
    @(negedge mclk);
    seq_start = 1'b0;
    seq_abort = 1'b0;
  endtask

  // Wait for a CTRL write of the given value to be on the bus (optionally in its ack cycle).
  task automatic wait_ctrl(input string name, input logic [31:0] wdata, input logic need_ack);
    bit seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge mclk);
      #2;
      if (reg_cs && reg_wr && reg_addr == 2'd0 && reg_wdata == wdata && (!need_ack || reg_ack))
        seen = 1'b1;
    end
    check({name, "_seen"}, 128'(seen), 128'(1));
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 2000 && !seen; n++) begin
      @(negedge mclk);
      if (seq_done) seen = 1'b1;
    end
    check({name, "_done_seen"}, 128'(seen), 128'(1));
    @(negedge mclk);
    #2;
    check({name, "_idle"}, 128'(seq_busy), 128'(0));
    check({name, "_bus_left"}, 128'(bus_q.size()), 128'(0));
    check({name, "_stat_left"}, 128'(stat_q.size()), 128'(0));
    bus_q.delete();
    stat_q.delete();
  endtask

  initial begin
    reset_n    = 1'b1;
    seq_start  = 1'b0;
    seq_abort  = 1'b0;
    cfg_num    = 2'd0;
    cfg_pat    = '0;
    cfg_depth  = '0;
    cfg_golden = '0;
    for (int i = 0; i < 4; i++) sig_tab[i] = 32'h0;
    #1 reset_n = 1'b0;
    #1;
    check("reset_outputs",
          128'({reg_cs, reg_wr, reg_addr, reg_wdata, reg_be, seq_busy, seq_done, seq_pass,
                seq_aborted, seq_fail_mask, seq_last_sig}), 128'(0));
    repeat (3) @(negedge mclk);
    reset_n = 1'b1;
    repeat (2) @(negedge mclk);

    // Single entry, done on the 3rd poll, matching signature.
    set_entry(0, 16'd16, 16'd8, 32'hA5A5_0001, 32'hA5A5_0001);
    done_after = 3;
    exp_entry(32'h0008_0010, 3, 1'b1);
    stat_q.push_back({1'b1, 1'b0, 4'b0000, 32'hA5A5_0001});
    start_seq(2'd0, 1'b0);
    check("t1_busy", 128'(seq_busy), 128'(1));
    wait_done("t1");

    // Four entries, entry 2 returns a wrong signature.
    done_after = 1;
    for (int i = 0; i < 4; i++) begin
      set_entry(i, 16'(16'h0100 + i), 16'(16'h0020 + i), 32'(32'h1111_0000 + i),
                (i == 2) ? 32'hDEAD_0002 : 32'(32'h1111_0000 + i));
      exp_entry(32'(32'h0020_0100 + i * 32'h0001_0001), 1, 1'b1);
    end
    stat_q.push_back({1'b0, 1'b0, 4'b0100, 32'h1111_0003});
    start_seq(2'd3, 1'b0);
    wait_done("t2");

    // Done never reported: exactly POLL_MAX CTRL reads, fail bit, then CLR.
    done_after = 0;
    set_entry(0, 16'h0040, 16'h0004, 32'h0, 32'h0);
    exp_entry(32'h0004_0040, 4, 1'b0);
    stat_q.push_back({1'b0, 1'b0, 4'b0001, 32'h1111_0003});
    start_seq(2'd0, 1'b0);
    wait_done("t3");

    // Abort while WR_START waits 5 cycles for ack.
    ack_delay  = 5;
    done_after = 1;
    set_entry(0, 16'h0007, 16'h0003, 32'h0, 32'h0);
    exp_bus(1'b1, 2'd1, 32'h0003_0007);
    exp_bus(1'b1, 2'd0, 32'd1);
    exp_bus(1'b1, 2'd0, 32'd2);
    exp_bus(1'b1, 2'd0, 32'd0);
    stat_q.push_back({1'b0, 1'b1, 4'b0000, 32'h1111_0003});
    start_seq(2'd1, 1'b0);
    wait_ctrl("t4_start_pending", 32'd2, 1'b0);
    seq_abort = 1'b1;
    @(negedge mclk);
    #2;
    seq_abort = 1'b0;
    wait_done("t4");
    ack_delay = 0;

    // A second start while busy has no effect.
    set_entry(0, 16'd16, 16'd8, 32'hA5A5_0001, 32'hA5A5_0001);
    exp_entry(32'h0008_0010, 1, 1'b1);
    stat_q.push_back({1'b1, 1'b0, 4'b0000, 32'hA5A5_0001});
    start_seq(2'd0, 1'b0);
    repeat (4) @(negedge mclk);
    seq_start = 1'b1;
    @(negedge mclk);
    seq_start = 1'b0;
    wait_done("t5");

    // Reset asserted while polling: outputs return to reset values immediately.
    done_after = 0;
    exp_bus(1'b1, 2'd1, 32'h0008_0010);
    exp_bus(1'b1, 2'd0, 32'd1);
    exp_bus(1'b1, 2'd0, 32'd2);
    start_seq(2'd0, 1'b0);
    wait_ctrl("t6_start_ack", 32'd2, 1'b1);
    @(posedge mclk);
    #2;
    check("t6_busy_in_poll", 128'(seq_busy), 128'(1));
    reset_n = 1'b0;
    #1;
    check("t6_reset_outputs",
          128'({reg_cs, reg_wr, reg_addr, reg_wdata, reg_be, seq_busy, seq_done, seq_pass,
                seq_aborted, seq_fail_mask, seq_last_sig}), 128'(0));
    check("t6_bus_left", 128'(bus_q.size()), 128'(0));
    bus_q.delete();
    repeat (2) @(negedge mclk);
    reset_n = 1'b1;
    repeat (2) @(negedge mclk);

    // Recovery from reset with simultaneous start+abort in IDLE, taken as a plain start.
    done_after = 3;
    exp_entry(32'h0008_0010, 3, 1'b1);
    stat_q.push_back({1'b1, 1'b0, 4'b0000, 32'hA5A5_0001});
    start_seq(2'd0, 1'b1);
    wait_done("t7");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lbist_seq.md
LBIST_SEQ -- requirements
Module: lbist_seq

Interface
REQ-001 SHALL have parameter NCFG, default 4, meaning number of test-configuration table entries.
REQ-002 SHALL have parameter POLL_GAP, default 16, meaning idle cycles between done-poll reads.
REQ-003 SHALL have parameter POLL_MAX, default 1024, meaning poll reads before timeout.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports mclk (input, 1, clock) and reset_n (input, 1, asynchronous active-low reset).
REQ-005 SHALL have seq_start, input, 1, a one-cycle pulse that starts a sequence.
REQ-006 SHALL have seq_abort, input, 1, a one-cycle pulse that aborts the sequence.
REQ-007 SHALL have cfg_num, input, 2, holding the number of entries minus 1.
REQ-008 SHALL have cfg_pat, input, NCFG*16, holding the pattern count per entry.
REQ-009 SHALL have cfg_depth, input, NCFG*16, holding the chain depth per entry.
REQ-010 SHALL have cfg_golden, input, NCFG*32, holding the expected signature per entry.
REQ-011 SHALL have the register-bus master outputs reg_cs (1), reg_wr (1), reg_addr (2), reg_wdata (32) and reg_be (4).
REQ-012 SHALL have the register-bus master inputs reg_rdata (32) and reg_ack (1).
REQ-013 SHALL have the status outputs seq_busy (1), seq_done (1, pulse), seq_pass (1), seq_aborted (1), seq_fail_mask (NCFG) and seq_last_sig (32).

Function
REQ-014 SHALL use LBIST register map: addr0 CTRL = bit0 srst, bit1 start, bit2 done (RO); addr1 CFG = {depth[31:16], pat[15:0]}; addr2 SIG (RO).
REQ-015 SHALL hold reg_cs and all request fields stable from assertion until the reg_ack cycle, deassert reg_cs in the cycle after ack, and drive reg_be = 4'hF.
REQ-016 SHALL step through states IDLE -> WR_CFG -> WR_SRST (CTRL=1) -> WR_START (CTRL=2) -> POLL_WAIT -> RD_CTRL -> RD_SIG -> WR_CLR (CTRL=0) -> NEXT -> DONE -> IDLE.
REQ-017 SHALL, in IDLE, accept seq_start only; seq_start while busy SHALL be ignored.
REQ-018 SHALL capture cfg_num at start and index entries 0..cfg_num; table inputs are sampled per entry in WR_CFG.
REQ-019 SHALL count POLL_GAP cycles in POLL_WAIT before each RD_CTRL; RD_CTRL with rdata[2]=1 -> RD_SIG, else increment poll counter -> POLL_WAIT.
REQ-020 SHALL, when the poll counter reaches POLL_MAX, set the entry's fail bit and go to WR_CLR with no RD_SIG.
REQ-021 SHALL, in RD_SIG, load seq_last_sig and set fail bit idx if rdata != golden[idx].
REQ-022 SHALL, in NEXT, go to DONE if idx == cfg_num, else increment idx and go to WR_CFG.
REQ-023 SHALL, in DONE, pulse seq_done for 1 cycle and set seq_pass = (seq_fail_mask == 0).
REQ-024 SHALL, on seq_abort while busy, finish any outstanding transaction (wait for ack), then issue WR_CLR, set seq_aborted=1 and seq_pass=0, then go to DONE.
REQ-025 SHALL ignore seq_abort in IDLE, and SHALL treat simultaneous start+abort in IDLE as start.
REQ-026 SHALL hold seq_busy=1 in every state except IDLE.
REQ-027 SHALL clear seq_fail_mask, seq_aborted and seq_pass on an accepted start.
REQ-028 SHALL wrap counters only by explicit reset, never by silent overflow; the poll counter SHALL be sized to hold POLL_MAX.

Reset
REQ-029 SHALL asynchronously force on reset: state IDLE; reg_cs, reg_wr, seq_busy, seq_done, seq_pass and seq_aborted = 0; reg_addr, reg_wdata, seq_fail_mask, seq_last_sig and counters = 0; reg_be = 0.
REQ-030 SHALL resume from IDLE after reset deassertion and need no bus transaction to recover.

Structure
REQ-031 SHALL place the register addresses, the CTRL bit positions and the state enum in package lbist_pkg.
REQ-032 SHALL implement the bus handshake as sub-module lbist_reg_master (req/ack to cs/ack).

Verification
REQ-033 SHALL verify: cfg_num=0, pat=16, depth=8, golden=32'hA5A5_0001 with a responder returning done on the 3rd poll and a matching SIG -> bus writes 0x0008_0010, 1, 2, 0 in order, then seq_done with seq_pass=1 and fail_mask=0.
REQ-034 SHALL verify: cfg_num=3 with entry 2 SIG mismatching -> seq_fail_mask=4'b0100 and seq_pass=0.
REQ-035 SHALL verify: a responder that never asserts done, with POLL_MAX=4 -> exactly 4 RD_CTRL reads, fail bit set, and WR_CLR issued.
REQ-036 SHALL verify: seq_abort during a pending WR_START with ack delayed 5 cycles -> WR_START completes, then CTRL=0 is written, seq_aborted=1 and seq_done pulses.
REQ-037 SHALL verify: seq_start pulsed while busy -> no effect; reset_n asserted mid-POLL -> all outputs at reset values within the same cycle.
REQ-038 SHALL verify: the assertion check that reg_addr and reg_wdata never change while reg_cs=1 and reg_ack=0.
